// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_pkg : shared types and constants for the data-memory arbiter        |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
package dmem_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_ISSUE   = 3'd1,
        ARB_WAIT_HI = 3'd2,
        ARB_WAIT_LO = 3'd3,
        ARB_DONE    = 3'd4
    } arb_state_e;

    // sign_mask field bits as understood by the memory block
    localparam logic [3:0] c_mask_signed = 4'b1000;
    localparam logic [3:0] c_mask_word   = 4'b0100;
    localparam logic [3:0] c_mask_half   = 4'b0010;
    localparam logic [3:0] c_mask_byte   = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/dmem_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_watchdog : handshake cycle counter; flags the cycle whose enabled   |
// |                 increment would reach TIMEOUT                            |
// | Rev 1.0       : initial release                                          |
// +--------------------------------------------------------------------------+
module dmem_watchdog
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TOW     = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TOW-1:0] c_last = TOW'(TIMEOUT - 1);

    logic [TOW-1:0] r_count_q;
    logic [TOW-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_clear) begin
            w_count_d = '0;
        end else if (i_enable) begin
            w_count_d = r_count_q + TOW'(1);
        end
    end

    // Kept independent of i_enable so the caller can gate it without a loop
    assign o_expired = (r_count_q == c_last);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter : round-robin sharing of the data-memory port between the   |
// |                load/store unit (port 0) and an auxiliary master (port 1) |
// | Rev 1.0      : initial release                                           |
// +--------------------------------------------------------------------------+
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TOW     = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_mask,
    output logic [31:0] p0_rdata,
    output logic        p0_done,
    output logic        p0_stall,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_mask,
    output logic [31:0] p1_rdata,
    output logic        p1_done,
    output logic        p1_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_stall,
    output logic        err
);

    arb_state_e  r_state_q,    w_state_d;
    logic        r_gnt_q,      w_gnt_d;
    logic        r_rr_last_q,  w_rr_last_d;
    logic        r_we_q,       w_we_d;
    logic [31:0] r_addr_q,     w_addr_d;
    logic [31:0] r_wdata_q,    w_wdata_d;
    logic [3:0]  r_mask_q,     w_mask_d;
    logic [31:0] r_p0_rdata_q, w_p0_rdata_d;
    logic [31:0] r_p1_rdata_q, w_p1_rdata_d;
    logic        r_err_q,      w_err_d;

    logic        w_win;
    logic        w_wd_clear;
    logic        w_wd_en;
    logic        w_wd_expired;
    logic        w_load;
    logic [31:0] w_load_val;

    // Under contention the port that did not win last time goes next
    assign w_win = (p0_req && p1_req) ? ~r_rr_last_q : p1_req;

    dmem_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TOW     (TOW)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_en),
        .o_expired (w_wd_expired)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_gnt_d      = r_gnt_q;
        w_rr_last_d  = r_rr_last_q;
        w_we_d       = r_we_q;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_mask_d     = r_mask_q;
        w_p0_rdata_d = r_p0_rdata_q;
        w_p1_rdata_d = r_p1_rdata_q;
        w_err_d      = r_err_q;
        w_wd_clear   = 1'b0;
        w_wd_en      = 1'b0;
        w_load       = 1'b0;
        w_load_val   = '0;

        case (r_state_q)
            ARB_IDLE: begin
                if (!mem_stall && (p0_req || p1_req)) begin
                    w_gnt_d     = w_win;
                    w_rr_last_d = w_win;
                    w_we_d      = w_win ? p1_we    : p0_we;
                    w_addr_d    = w_win ? p1_addr  : p0_addr;
                    w_wdata_d   = w_win ? p1_wdata : p0_wdata;
                    w_mask_d    = w_win ? p1_mask  : p0_mask;
                    w_wd_clear  = 1'b1;
                    w_state_d   = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                w_state_d = ARB_WAIT_HI;
            end
            ARB_WAIT_HI: begin
                if (mem_stall) begin
                    w_wd_clear = 1'b1;
                    w_state_d  = ARB_WAIT_LO;
                end else begin
                    w_wd_en = 1'b1;
                end
            end
            ARB_WAIT_LO: begin
                if (!mem_stall) begin
                    w_load     = ~r_we_q;
                    w_load_val = mem_rdata;
                    w_state_d  = ARB_DONE;
                end else begin
                    w_wd_en = 1'b1;
                end
            end
            ARB_DONE: begin
                w_state_d = ARB_IDLE;
            end
            default: begin
                w_state_d = ARB_IDLE;
            end
        endcase

        // A stuck handshake completes the access with zero data
        if (w_wd_en && w_wd_expired) begin
            w_err_d    = 1'b1;
            w_load     = 1'b1;
            w_load_val = '0;
            w_state_d  = ARB_DONE;
        end

        if (w_load) begin
            if (r_gnt_q) begin
                w_p1_rdata_d = w_load_val;
            end else begin
                w_p0_rdata_d = w_load_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state_q    <= ARB_IDLE;
            r_gnt_q      <= 1'b0;
            r_rr_last_q  <= 1'b1;
            r_we_q       <= 1'b0;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_mask_q     <= '0;
            r_p0_rdata_q <= '0;
            r_p1_rdata_q <= '0;
            r_err_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_gnt_q      <= w_gnt_d;
            r_rr_last_q  <= w_rr_last_d;
            r_we_q       <= w_we_d;
            r_addr_q     <= w_addr_d;
            r_wdata_q    <= w_wdata_d;
            r_mask_q     <= w_mask_d;
            r_p0_rdata_q <= w_p0_rdata_d;
            r_p1_rdata_q <= w_p1_rdata_d;
            r_err_q      <= w_err_d;
        end
    end

    assign mem_read  = (r_state_q == ARB_ISSUE) && !r_we_q;
    assign mem_write = (r_state_q == ARB_ISSUE) &&  r_we_q;
    assign mem_addr  = r_addr_q;
    assign mem_wdata = r_wdata_q;
    assign mem_mask  = r_mask_q;

    assign p0_done  = (r_state_q == ARB_DONE) && !r_gnt_q;
    assign p1_done  = (r_state_q == ARB_DONE) &&  r_gnt_q;
    assign p0_rdata = r_p0_rdata_q;
    assign p1_rdata = r_p1_rdata_q;
    assign p0_stall = p0_req & ~p0_done;
    assign p1_stall = p1_req & ~p1_done;
    assign err      = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_arbiter : directed bench with a latency-based reference model    |
// | Rev 1.0         : initial release                                        |
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;

    localparam int TIMEOUT  = 16;
    localparam int TOW      = 5;
    localparam int LAT_NORM = 4;             // grant edge to DONE with a 2-cycle memory stall
    localparam int LAT_TO   = TIMEOUT + 1;   // grant edge to DONE when stall never rises

    logic        clk;
    logic        reset_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_mask, p1_mask;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_done, p0_stall, p1_done, p1_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_stall;
    logic [3:0]  mem_mask;
    logic        err;

    dmem_arbiter #(.TIMEOUT(TIMEOUT), .TOW(TOW)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_mask(p0_mask), .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_stall(p0_stall),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_mask(p1_mask), .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_stall(p1_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_mask(mem_mask), .mem_rdata(mem_rdata),
        .mem_stall(mem_stall), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    int mem_mode = 0;   // 0: memory stalls 2 cycles per access, 1: memory never responds

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d: no done pulse within the cycle budget", name, cyc);
    endtask

    // Memory responder: sees the request in ISSUE, stalls for 2 cycles, then returns data
    logic [31:0] bmem [logic [31:0]];
    initial begin : memory_model
        bit          pend;
        int          cnt;
        logic [31:0] a;
        pend = 1'b0; cnt = 0; a = '0;
        mem_stall = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                pend = 1'b0; cnt = 0; mem_stall = 1'b0;
            end else if (mem_read || mem_write) begin
                if (mem_mode == 0) begin
                    pend = 1'b1;
                    a    = mem_addr;
                    if (mem_write) bmem[a] = mem_wdata;
                end
            end else if (pend) begin
                pend = 1'b0; mem_stall = 1'b1; cnt = 1;
            end else if (cnt > 0) begin
                cnt--;
            end else if (mem_stall) begin
                mem_stall = 1'b0;
                mem_rdata = bmem.exists(a) ? bmem[a] : 32'h0;
            end
        end
    end

    // Reference model: each access is a timestamped transaction
    logic [31:0] ref_mem [logic [31:0]];
    bit          m_busy, m_owner, m_rr, m_we, m_to, m_err;
    int          m_g, m_lat;
    logic [31:0] m_addr, m_wdata, m_rd0, m_rd1;
    logic [3:0]  m_mask;

    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            m_busy = 0; m_rr = 1; m_owner = 0; m_we = 0; m_to = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_mask = '0; m_rd0 = '0; m_rd1 = '0;
        end else if (m_busy) begin
            if (cyc == m_g + m_lat) begin
                if (m_to) begin
                    m_err = 1'b1;
                    if (m_owner) m_rd1 = '0; else m_rd0 = '0;
                end else if (!m_we) begin
                    if (m_owner) m_rd1 = ref_mem.exists(m_addr) ? ref_mem[m_addr] : 32'h0;
                    else         m_rd0 = ref_mem.exists(m_addr) ? ref_mem[m_addr] : 32'h0;
                end
            end else if (cyc == m_g + m_lat + 1) begin
                m_busy = 1'b0;
            end
        end else if (!mem_stall && (p0_req || p1_req)) begin
            m_owner = (p0_req && p1_req) ? !m_rr : p1_req;
            m_rr    = m_owner;
            m_we    = m_owner ? p1_we    : p0_we;
            m_addr  = m_owner ? p1_addr  : p0_addr;
            m_wdata = m_owner ? p1_wdata : p0_wdata;
            m_mask  = m_owner ? p1_mask  : p0_mask;
            m_busy  = 1'b1;
            m_g     = cyc;
            m_to    = (mem_mode == 1);
            m_lat   = m_to ? LAT_TO : LAT_NORM;
            if (m_we && !m_to) ref_mem[m_addr] = m_wdata;
        end
    end

    int          rd_pulses = 0, wr_pulses = 0, d0cnt = 0;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_mask;

    always @(posedge clk) begin : compare
        bit e_issue, e_done, e_d0, e_d1;
        #2;
        if (chk_en) begin
            e_issue = m_busy && (cyc == m_g);
            e_done  = m_busy && (cyc == m_g + m_lat);
            e_d0    = e_done && !m_owner;
            e_d1    = e_done &&  m_owner;
            check("mem_read",  mem_read,  e_issue && !m_we);
            check("mem_write", mem_write, e_issue &&  m_we);
            check("mem_addr",  mem_addr,  m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
            check("mem_mask",  mem_mask,  m_mask);
            check("p0_done",   p0_done,   e_d0);
            check("p1_done",   p1_done,   e_d1);
            check("p0_rdata",  p0_rdata,  m_rd0);
            check("p1_rdata",  p1_rdata,  m_rd1);
            check("p0_stall",  p0_stall,  p0_req & ~e_d0);
            check("p1_stall",  p1_stall,  p1_req & ~e_d1);
            check("err",       err,       m_err);
            check("rw_excl",   mem_read & mem_write, 0);
            check("done_excl", p0_done & p1_done, 0);
            if (mem_read === 1'b1) rd_pulses++;
            if (mem_write === 1'b1) begin
                wr_pulses++; wr_addr = mem_addr; wr_data = mem_wdata; wr_mask = mem_mask;
            end
            if (p0_done === 1'b1) d0cnt++;
        end
    end

    task automatic set_req(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_mask = mask;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_mask = mask;
        end
    endtask

    task automatic wait_done(input bit port, input int budget, input string name, output int dcyc);
        dcyc = -1;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk); #2;
            if ((!port && p0_done === 1'b1) || (port && p1_done === 1'b1)) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) fail_msg(name);
    endtask

    initial begin : global_guard
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int t0, d, nd, st0, first;
        int order [4];
        reset_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_mask = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_mask = '0;
        bmem[32'h1004]    = 32'hDEADBEEF;  ref_mem[32'h1004] = 32'hDEADBEEF;
        bmem[32'h2000]    = 32'hCAFEF00D;  ref_mem[32'h2000] = 32'hCAFEF00D;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_ctrl",  {mem_read, mem_write, p0_done, p1_done, err}, 0);
        check("reset_rdata", {p0_rdata, p1_rdata}, 0);
        reset_n = 1'b1;

        // single read on port 0
        @(negedge clk);
        rd_pulses = 0;
        set_req(0, 0, 32'h1004, 32'h0, 4'b0100);
        t0 = cyc;
        #1 st0 = (p0_stall === 1'b1) ? 1 : 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #2;
            if (p0_stall === 1'b1) st0++;
            if (p0_done === 1'b1) break;
        end
        check("t1_latency",  cyc - t0, 5);
        check("t1_rdata",    p0_rdata, 32'hDEADBEEF);
        check("t1_rd_pulse", rd_pulses, 1);
        check("t1_stall_cycles", st0, 5);
        @(negedge clk); p0_req = 0;

        // single write on port 1
        @(negedge clk);
        wr_pulses = 0;
        set_req(1, 1, 32'h1008, 32'h12345678, 4'h4);
        wait_done(1, 30, "t2_done", d);
        check("t2_wr_pulse", wr_pulses, 1);
        check("t2_wr_addr",  wr_addr, 32'h1008);
        check("t2_wr_data",  wr_data, 32'h12345678);
        check("t2_wr_mask",  wr_mask, 4'h4);
        check("t2_p1_rdata", p1_rdata, 32'h0);
        @(negedge clk); p1_req = 0;

        // continuous contention, four accesses
        @(negedge clk);
        set_req(0, 0, 32'h1004, 32'h0, 4'b0100);
        set_req(1, 0, 32'h1008, 32'h0, 4'b0100);
        nd = 0;
        for (int n = 0; n < 80 && nd < 4; n++) begin
            @(posedge clk); #2;
            if (p0_done === 1'b1) begin order[nd] = 0; nd++; end
            else if (p1_done === 1'b1) begin order[nd] = 1; nd++; end
        end
        if (nd < 4) fail_msg("t3_budget");
        for (int i = 0; i < nd; i++) check($sformatf("t3_grant%0d", i), order[i], i % 2);
        check("t3_p1_rdata", p1_rdata, 32'h12345678);
        @(negedge clk); p0_req = 0; p1_req = 0;

        // handshake timeout, then a good access with err still set
        @(negedge clk);
        mem_mode = 1;
        set_req(0, 0, 32'h1004, 32'h0, 4'b0100);
        t0 = cyc;
        wait_done(0, 40, "t4_done", d);
        check("t4_latency", d - t0, 18);
        check("t4_rdata",   p0_rdata, 32'h0);
        check("t4_err",     err, 1);
        @(negedge clk); p0_req = 0; mem_mode = 0;
        @(negedge clk);
        set_req(1, 0, 32'h1008, 32'h0, 4'b0100);
        wait_done(1, 30, "t4b_done", d);
        check("t4b_rdata", p1_rdata, 32'h12345678);
        check("t4b_err",   err, 1);
        @(negedge clk); p1_req = 0;

        // reset during WAIT_LO
        @(negedge clk);
        d0cnt = 0;
        set_req(0, 0, 32'h1004, 32'h0, 4'b0100);
        t0 = cyc;
        while (cyc < t0 + 3) @(negedge clk);
        reset_n = 1'b0; p0_req = 0;
        @(posedge clk); #2;
        check("t5_ctrl_zero",  {mem_read, mem_write, mem_mask, p0_done, p1_done, err, p0_stall, p1_stall}, 0);
        check("t5_bus_zero",   {mem_addr, mem_wdata}, 0);
        check("t5_rdata_zero", {p0_rdata, p1_rdata}, 0);
        check("t5_no_done",    d0cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        set_req(0, 0, 32'h1004, 32'h0, 4'b0100);
        set_req(1, 0, 32'h1008, 32'h0, 4'b0100);
        t0 = cyc; first = -1;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #2;
            if (p0_done === 1'b1) begin first = 0; break; end
            if (p1_done === 1'b1) begin first = 1; break; end
        end
        if (first < 0) fail_msg("t5_first_done");
        check("t5_first_port", first, 0);
        check("t5_latency",    cyc - t0, 5);
        check("t5_p0_rdata",   p0_rdata, 32'hDEADBEEF);
        @(negedge clk); p0_req = 0;
        wait_done(1, 30, "t5_p1_done", d);
        check("t5_p1_rdata", p1_rdata, 32'h12345678);
        @(negedge clk); p1_req = 0;

        // request dropped right after grant
        @(negedge clk);
        d0cnt = 0;
        set_req(0, 0, 32'h2000, 32'h0, 4'b0100);
        @(negedge clk); p0_req = 0;
        repeat (15) @(posedge clk);
        #2;
        check("t6_done_count", d0cnt, 1);
        check("t6_rdata",      p0_rdata, 32'hCAFEF00D);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single SPRAM-backed data memory port between two requesters: port 0 (CPU load/store unit) and port 1 (auxiliary master, e.g. debug/loader).
- Sequences each access through the memory's one-cycle request and clk_stall protocol, returns read data, and stalls whichever requester is waiting.
- Sits between the pipeline MEM stage and the data memory block.
- Arbitration is round-robin on contention, with a watchdog on the memory handshake.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_stall to rise or fall before aborting the access.
- TOW, 5, width of the timeout counter; must satisfy 2**TOW > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- p0_req  in  1  port 0 request; held high until p0_done
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  32  port 0 byte address
- p0_wdata  in  32  port 0 write data
- p0_mask  in  4  port 0 sign_mask encoding, passed through unchanged
- p0_rdata  out  32  port 0 read data; valid when p0_done=1
- p0_done  out  1  one-cycle completion pulse
- p0_stall  out  1  equals p0_req & ~p0_done
- p1_req, p1_we, p1_addr, p1_wdata, p1_mask, p1_rdata, p1_done, p1_stall: same widths and meanings for port 1
- mem_addr  out  32  to memory addr
- mem_wdata  out  32  to memory write_data
- mem_read  out  1  to memory memread
- mem_write  out  1  to memory memwrite
- mem_mask  out  4  to memory sign_mask
- mem_rdata  in  32  from memory read_data
- mem_stall  in  1  from memory clk_stall
- err  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; rr_last=1, so port 0 wins the first contention.
  - All outputs 0, err=0, counter=0.
  - Reset mid-access abandons the access with no done pulse; the memory block is expected to finish its own FSM within 3 cycles.
- Each accepted request goes IDLE -> ISSUE -> WAIT_HI -> WAIT_LO -> DONE -> IDLE.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port not equal to rr_last.
  - On grant: latch the winner's we/addr/wdata/mask into internal registers; set gnt and rr_last=gnt; go to ISSUE.
  - If neither is high, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_read=~we_q and mem_write=we_q, each high for this single cycle only.
  - mem_addr, mem_wdata, mem_mask driven from the latched registers; they hold their values through DONE.
  - Go to WAIT_HI.
- WAIT_HI:
  - If mem_stall=1: go to WAIT_LO and clear the counter.
  - Otherwise increment the counter; when it reaches TIMEOUT, set err=1, force rdata=0, go to DONE.
- WAIT_LO:
  - If mem_stall=0: capture mem_rdata into rdata_q (reads only; writes keep rdata_q unchanged) and go to DONE.
  - Same timeout rule as WAIT_HI.
- DONE (1 cycle):
  - p<gnt>_done=1 and p<gnt>_rdata=rdata_q.
  - Go to IDLE; the next grant can be taken in that IDLE cycle.
  - Minimum access latency, req to done: read 5 cycles, write 5 cycles.
- pN_rdata holds its last value between accesses. done is never asserted for the non-granted port.
- A req deasserted after grant does not abort the access; done still pulses.
- A request arriving during a busy access waits; round-robin alternates under continuous contention, so neither port starves.
- mem_read and mem_write are never both high. No new ISSUE is sent while mem_stall=1 (the IDLE grant also requires mem_stall=0).
- Address, mask and data are passed unmodified. Byte-lane and sign handling remain in the memory block.

Decomposition:
- Shared package dmem_pkg:
  - state encodings ARB_IDLE=0, ARB_ISSUE=1, ARB_WAIT_HI=2, ARB_WAIT_LO=3, ARB_DONE=4.
  - sign_mask field constants (bit3 signed, bit2 word, bit1 half, bit0 byte).
- One natural sub-module, dmem_watchdog: a counter with clear/enable inputs and an expired output, parameterised by TIMEOUT and TOW.

Test Plan:
- Single read: p0 read addr 0x1004, memory model returns 0xDEADBEEF. Required: mem_read high exactly 1 cycle; p0_done 5 cycles after p0_req; p0_rdata=0xDEADBEEF; p0_stall high for 5 cycles.
- Single write: p1 write 0x1008, data 0x12345678, mask 0x4. Required: mem_write pulse 1 cycle with mem_addr=0x1008, mem_wdata=0x12345678, mem_mask=0x4; p1_done pulses; p1_rdata unchanged.
- Contention: p0 and p1 both request continuously for 4 accesses. Required: grants in order p0, p1, p0, p1; no cycle with both done pulses; mem_read and mem_write never overlap.
- Timeout: memory model never raises mem_stall. Required: after 16 cycles in WAIT_HI, err=1, done pulses with rdata=0; err stays 1 through later good accesses.
- Reset mid-access: reset_n=0 for 1 cycle during WAIT_LO. Required: all outputs 0 next cycle, no done pulse; after reset a fresh p0 read completes normally and port 0 wins the next contention.
- Early req drop: p0_req deasserted the cycle after grant. Required: access completes and p0_done still pulses once.
